ternary_mvm_stream: RTL and testbench

Parametrised streaming ternary matrix-vector multiplier, the successor to the fixed 14x7, 2-lane multiplier.
- Each beat supplies Lanes input elements and their Lanes x OutLen ternary weights.
- Accumulates InLen/Lanes beats per vector into OutLen signed accumulators.
- Commits results to a double buffer and drains them serially on a valid/ready output port while the next vector accumulates.

---
 rtl/ternary_mvm_stream.sv | 140 ++++++++++++++
 tb/tb_ternary_mvm_stream.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_mvm_stream.sv
// Streaming ternary matrix-vector multiplier. Lanes elements per beat are accumulated
// into OutLen signed columns, then committed to a buffer that drains one word per handshake.
module ternary_mvm_stream #(
  parameter  int InLen    = 14,
  parameter  int OutLen   = 7,
  parameter  int Lanes    = 2,
  parameter  int BitWidth = 8,
  parameter  int AccWidth = 12,
  parameter  int Saturate = 1,
  localparam int IdxW     = (OutLen > 1) ? $clog2(OutLen) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [Lanes*BitWidth-1:0]    vec_in,
  input  logic [Lanes*OutLen*2-1:0]    w_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BitWidth-1:0]          out_data,
  output logic [IdxW-1:0]              out_idx,
  output logic                         out_last
);

  localparam int Steps = InLen / Lanes;
  localparam int CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic signed [AccWidth-1:0] SatMax =
    {{(AccWidth-BitWidth+1){1'b0}}, {(BitWidth-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] SatMin =
    {{(AccWidth-BitWidth+1){1'b1}}, {(BitWidth-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                      state, state_next;
  logic [CntW-1:0]             beat_cnt;
  logic [IdxW-1:0]             idx;
  logic                        buf_full;
  logic signed [AccWidth-1:0]  acc     [OutLen];
  logic signed [AccWidth-1:0]  res_buf [OutLen];
  logic signed [AccWidth-1:0]  sum     [OutLen];
  logic signed [AccWidth-1:0]  elem    [Lanes];
  logic signed [AccWidth-1:0]  sel;
  logic                        last_beat, out_hs, accept, commit;

  for (genvar l = 0; l < Lanes; l++) begin : g_ext
    assign elem[l] = {{(AccWidth-BitWidth){vec_in[l*BitWidth+BitWidth-1]}},
                      vec_in[l*BitWidth +: BitWidth]};
  end

  assign last_beat = (beat_cnt == CntW'(Steps-1));
  assign out_hs    = out_valid && out_ready;
  // Final beat may enter in the same cycle the previous vector's last word leaves.
  assign in_ready  = !last_beat || !buf_full || (out_hs && out_last);
  assign accept    = in_valid && in_ready && !clr;
  assign commit    = accept && last_beat;

  // beat_cnt==0 masks stale accumulators, so they never need clearing between vectors.
  always_comb begin
    for (int c = 0; c < OutLen; c++) begin
      sum[c] = (beat_cnt == '0) ? '0 : acc[c];
      for (int l = 0; l < Lanes; l++) begin
        case (w_in[(l*OutLen+c)*2 +: 2])
          2'b01:        sum[c] = sum[c] + elem[l];
          2'b10, 2'b11: sum[c] = sum[c] - elem[l];
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      idx      <= '0;
      buf_full <= 1'b0;
      for (int c = 0; c < OutLen; c++) begin
        acc[c]     <= '0;
        res_buf[c] <= '0;
      end
    end else begin
      if (clr) begin
        beat_cnt <= '0;
      end else if (accept) begin
        if (last_beat) begin
          beat_cnt <= '0;
          for (int c = 0; c < OutLen; c++) res_buf[c] <= sum[c];
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          for (int c = 0; c < OutLen; c++) acc[c] <= sum[c];
        end
      end
      if (commit) begin
        buf_full <= 1'b1;
        idx      <= '0;
      end else if (out_hs) begin
        if (out_last) begin
          buf_full <= 1'b0;
          idx      <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (commit) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_hs && out_last && !commit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_idx  = idx;
  assign out_last = out_valid && (idx == IdxW'(OutLen-1));

  always_comb begin
    sel      = res_buf[idx];
    out_data = '0;
    if (out_valid) begin
      if (Saturate != 0 && sel > SatMax)      out_data = SatMax[BitWidth-1:0];
      else if (Saturate != 0 && sel < SatMin) out_data = SatMin[BitWidth-1:0];
      else                                    out_data = sel[BitWidth-1:0];
    end
  end

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// Bench for ternary_mvm_stream: a saturating and a wrapping instance share all inputs and
// are checked against a dot-product reference model and directed protocol expectations.
module tb_ternary_mvm_stream;

  localparam int InLen    = 4;
  localparam int OutLen   = 3;
  localparam int Lanes    = 2;
  localparam int BitWidth = 8;
  localparam int AccWidth = 12;
  localparam int VW       = Lanes*BitWidth;
  localparam int WW       = Lanes*OutLen*2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] vec_in = '0;
  logic [WW-1:0] w_in = '0;

  logic       in_ready_s, out_valid_s, out_last_s;
  logic [7:0] out_data_s;
  logic [1:0] out_idx_s;
  logic       in_ready_w, out_valid_w, out_last_w;
  logic [7:0] out_data_w;
  logic [1:0] out_idx_w;

  int testsRun = 0;
  int failCount = 0;
  int exp_q[$];
  int exp_idx = 0;
  int part_x[InLen];
  int part_c[InLen][OutLen];
  int part_n = 0;
  bit randomReady = 1'b0;

  ternary_mvm_stream #(.InLen(InLen), .OutLen(OutLen), .Lanes(Lanes), .BitWidth(BitWidth),
                       .AccWidth(AccWidth), .Saturate(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .vec_in(vec_in), .w_in(w_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_idx(out_idx_s), .out_last(out_last_s));

  ternary_mvm_stream #(.InLen(InLen), .OutLen(OutLen), .Lanes(Lanes), .BitWidth(BitWidth),
                       .AccWidth(AccWidth), .Saturate(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
    .vec_in(vec_in), .w_in(w_in), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_idx(out_idx_w), .out_last(out_last_w));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int satConv(input int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int wrapConv(input int x);
    int r;
    r = ((x % 256) + 256) % 256;
    return (r > 127) ? r - 256 : r;
  endfunction

  function automatic logic [VW-1:0] pv(input int a, input int b);
    logic [31:0] ua, ub;
    ua = a;
    ub = b;
    return {ub[7:0], ua[7:0]};
  endfunction

  function automatic logic [WW-1:0] pw(input logic [1:0] l0c0, l0c1, l0c2, l1c0, l1c1, l1c2);
    return {l1c2, l1c1, l1c0, l0c2, l0c1, l0c0};
  endfunction

  // Reference: collect accepted elements, then form each column's dot product in one go.
  task automatic modelAccept(input logic [VW-1:0] v, input logic [WW-1:0] w);
    int s;
    for (int l = 0; l < Lanes; l++) begin
      part_x[part_n+l] = $signed(v[l*BitWidth +: BitWidth]);
      for (int c = 0; c < OutLen; c++) part_c[part_n+l][c] = int'(w[(l*OutLen+c)*2 +: 2]);
    end
    part_n += Lanes;
    if (part_n == InLen) begin
      for (int c = 0; c < OutLen; c++) begin
        s = 0;
        for (int i = 0; i < InLen; i++) begin
          if (part_c[i][c] == 1)      s += part_x[i];
          else if (part_c[i][c] >= 2) s -= part_x[i];
        end
        exp_q.push_back(s);
      end
      part_n = 0;
    end
  endtask

  task automatic resetModel();
    exp_q.delete();
    exp_idx = 0;
    part_n = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_s) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_word", 1, 0);
      end else begin
        checkOutput("data_sat", int'($signed(out_data_s)), satConv(exp_q[0]));
        checkOutput("data_wrap", int'($signed(out_data_w)), wrapConv(exp_q[0]));
        checkOutput("out_idx", int'(out_idx_s), exp_idx);
        checkOutput("out_idx_wrap", int'(out_idx_w), exp_idx);
        checkOutput("out_last", int'(out_last_s), (exp_idx == OutLen-1) ? 1 : 0);
        checkOutput("out_valid_wrap", int'(out_valid_w), 1);
        if (out_ready) begin
          void'(exp_q.pop_front());
          exp_idx = (exp_idx == OutLen-1) ? 0 : exp_idx + 1;
        end
      end
    end
  end

  task automatic waitAccept(input logic [VW-1:0] v, input logic [WW-1:0] w);
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (in_ready_s && !clr) begin
        modelAccept(v, w);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done && randomReady) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [VW-1:0] v, input logic [WW-1:0] w);
    vec_in = v;
    w_in = w;
    in_valid = 1'b1;
    if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
    waitAccept(v, w);
  endtask

  task automatic waitDrain();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain_complete", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [VW-1:0] vb2;
  logic [WW-1:0] wb2;

  initial begin
    // Reset values and quiet idle after release
    #1;
    checkOutput("rst_out_valid", int'(out_valid_s), 0);
    checkOutput("rst_in_ready", int'(in_ready_s), 1);
    checkOutput("rst_out_data", int'(out_data_s), 0);
    checkOutput("rst_out_idx", int'(out_idx_s), 0);
    checkOutput("rst_out_last", int'(out_last_s), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_out_valid", int'(out_valid_s), 0);
      @(posedge clk); #1;
    end

    // Basic vector: 5, 2, 3 with first word the cycle after the final beat
    out_ready = 1'b1;
    applyStimulus(pv(10, -3), pw(2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10));
    applyStimulus(pv(5, 7),   pw(2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00));
    @(negedge clk);
    checkOutput("basic_latency_valid", int'(out_valid_s), 1);
    checkOutput("basic_w0", int'($signed(out_data_s)), 5);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("basic_w1", int'($signed(out_data_s)), 2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("basic_w2", int'($signed(out_data_s)), 3);
    checkOutput("basic_last", int'(out_last_s), 1);
    @(posedge clk); #1;
    waitDrain();

    // Saturation and wrap
    applyStimulus(pv(127, 127), pw(1, 1, 1, 1, 1, 1));
    applyStimulus(pv(127, 127), pw(1, 1, 1, 1, 1, 1));
    @(negedge clk);
    checkOutput("sat_pos", int'($signed(out_data_s)), 127);
    checkOutput("wrap_pos", int'($signed(out_data_w)), -4);
    @(posedge clk); #1;
    waitDrain();
    applyStimulus(pv(127, 127), pw(2, 2, 2, 2, 2, 2));
    applyStimulus(pv(127, 127), pw(2, 2, 2, 2, 2, 2));
    @(negedge clk);
    checkOutput("sat_neg", int'($signed(out_data_s)), -128);
    @(posedge clk); #1;
    waitDrain();
    applyStimulus(pv(-128, -128), pw(3, 3, 3, 3, 3, 3));
    applyStimulus(pv(-128, -128), pw(3, 3, 3, 3, 3, 3));
    @(negedge clk);
    checkOutput("sat_negneg", int'($signed(out_data_s)), 127);
    @(posedge clk); #1;
    waitDrain();

    // Backpressure with A stalled, then B's final beat overlapping A's last handshake
    out_ready = 1'b0;
    applyStimulus(pv(20, -7),  pw(1, 2, 3, 0, 1, 2));
    applyStimulus(pv(-50, 33), pw(2, 2, 1, 1, 0, 3));
    applyStimulus(pv(90, -90), pw(1, 1, 2, 3, 0, 1));
    vb2 = pv(-17, 64);
    wb2 = pw(2, 1, 1, 1, 3, 0);
    vec_in = vb2;
    w_in = wb2;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", int'(in_ready_s), 0);
      checkOutput("bp_out_valid", int'(out_valid_s), 1);
      checkOutput("bp_hold_idx", int'(out_idx_s), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("ov_in_ready_w0", int'(in_ready_s), 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ov_in_ready_w1", int'(in_ready_s), 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ov_in_ready_last", int'(in_ready_s), 1);
    modelAccept(vb2, wb2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("ov_out_valid", int'(out_valid_s), 1);
    checkOutput("ov_out_idx", int'(out_idx_s), 0);
    @(posedge clk); #1;
    waitDrain();

    // clr after beat 1 drops both the partial vector and the coincident beat
    applyStimulus(pv(100, 100), pw(1, 1, 1, 1, 1, 1));
    vec_in = pv(50, 50);
    w_in = pw(1, 1, 1, 1, 1, 1);
    in_valid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    checkOutput("clr_in_ready", int'(in_ready_s), 1);
    part_n = 0;
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    applyStimulus(pv(3, -4),  pw(1, 2, 3, 0, 1, 1));
    applyStimulus(pv(-6, 9),  pw(2, 0, 1, 1, 1, 3));
    waitDrain();

    // Asynchronous reset mid-drain at idx 1
    applyStimulus(pv(11, 22),  pw(1, 1, 2, 2, 0, 1));
    applyStimulus(pv(33, -44), pw(1, 2, 1, 2, 1, 1));
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("arst_out_valid", int'(out_valid_s), 0);
    checkOutput("arst_out_idx", int'(out_idx_s), 0);
    checkOutput("arst_out_data", int'(out_data_s), 0);
    checkOutput("arst_in_ready", int'(in_ready_s), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", int'(out_valid_s), 0);
      @(posedge clk); #1;
    end

    // Randomized vectors with random backpressure and input gaps
    randomReady = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int b = 0; b < InLen/Lanes; b++) begin
        applyStimulus(VW'($urandom), WW'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    randomReady = 1'b0;
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
